// File: rtl/pwl_table_loader.sv
// Double-buffered PWL coefficient table: streams {offset, slope} words into the shadow bank and swaps it in atomically.
// Optional trailer checksum before the swap: define PWL_LOAD_CHECKSUM_EN.
module pwl_table_loader #(
   parameter int ADDR_BITS   = 8,
   parameter int OFFSET_BITS = 18,
   parameter int SLOPE_BITS  = 18,
   parameter int DATA_BITS   = OFFSET_BITS + SLOPE_BITS
) (
   input  logic                 clk_sys,
   input  logic                 rst,
   input  logic                 load_start,
   input  logic                 wr_valid,
   output logic                 wr_ready,
   input  logic [DATA_BITS-1:0] wr_data,
   output logic                 load_busy,
   output logic                 load_done,
   output logic                 load_err,
   output logic                 active_bank,
   input  logic [ADDR_BITS-1:0] rd_addr,
   output logic [DATA_BITS-1:0] rd_data
);

   localparam int DEPTH = 1 << ADDR_BITS;
   localparam logic [ADDR_BITS-1:0] LAST_ADDR = '1;

`ifdef PWL_LOAD_CHECKSUM_EN
   typedef enum logic [1:0] {IDLE, LOAD, CHECK} state_t;
`else
   typedef enum logic [0:0] {IDLE, LOAD} state_t;
`endif

   state_t               state, state_nxt;
   logic [ADDR_BITS-1:0] wr_ptr, wr_ptr_nxt;
   logic                 bank_nxt;
   logic                 done_nxt;
   logic                 mem_we;
   logic                 accept;
`ifdef PWL_LOAD_CHECKSUM_EN
   logic [DATA_BITS-1:0] sum, sum_nxt;
   logic                 err_nxt;
`endif

   // Both banks in one array; the bank bit is the address MSB.
   logic [DATA_BITS-1:0] mem [2*DEPTH];

   assign wr_ready  = (state != IDLE);
   assign load_busy = (state != IDLE);
   assign accept    = wr_valid & wr_ready;

   always_comb begin
      state_nxt  = state;
      wr_ptr_nxt = wr_ptr;
      bank_nxt   = active_bank;
      done_nxt   = 1'b0;
      mem_we     = 1'b0;
`ifdef PWL_LOAD_CHECKSUM_EN
      err_nxt    = load_err;
      sum_nxt    = sum;
`endif
      // load_start wins over a word accepted in the same cycle; that word is dropped.
      if (load_start) begin
         state_nxt  = LOAD;
         wr_ptr_nxt = '0;
`ifdef PWL_LOAD_CHECKSUM_EN
         err_nxt    = 1'b0;
         sum_nxt    = '0;
`endif
      end else if (accept) begin
         case (state)
            LOAD: begin
               mem_we     = 1'b1;
               wr_ptr_nxt = wr_ptr + 1'b1;
`ifdef PWL_LOAD_CHECKSUM_EN
               sum_nxt    = sum + wr_data;
               if (wr_ptr == LAST_ADDR) state_nxt = CHECK;
`else
               if (wr_ptr == LAST_ADDR) begin
                  bank_nxt  = ~active_bank;
                  done_nxt  = 1'b1;
                  state_nxt = IDLE;
               end
`endif
            end
`ifdef PWL_LOAD_CHECKSUM_EN
            CHECK: begin
               state_nxt = IDLE;
               if (wr_data == sum) begin
                  bank_nxt = ~active_bank;
                  done_nxt = 1'b1;
               end else begin
                  err_nxt = 1'b1;
               end
            end
`endif
            default: ;
         endcase
      end
   end

   always_ff @(posedge clk_sys or posedge rst) begin
      if (rst) begin
         state       <= IDLE;
         wr_ptr      <= '0;
         active_bank <= 1'b0;
         load_done   <= 1'b0;
`ifdef PWL_LOAD_CHECKSUM_EN
         load_err    <= 1'b0;
         sum         <= '0;
`endif
      end else begin
         state       <= state_nxt;
         wr_ptr      <= wr_ptr_nxt;
         active_bank <= bank_nxt;
         load_done   <= done_nxt;
`ifdef PWL_LOAD_CHECKSUM_EN
         load_err    <= err_nxt;
         sum         <= sum_nxt;
`endif
      end
   end

`ifndef PWL_LOAD_CHECKSUM_EN
   assign load_err = 1'b0;
`endif

   // Writes only ever target the shadow bank, so the read port never sees a partial table.
   always_ff @(posedge clk_sys) begin
      if (mem_we) mem[{~active_bank, wr_ptr}] <= wr_data;
   end

   // The read samples the pre-swap bank on the swap edge; the new bank shows from the next edge.
   always_ff @(posedge clk_sys or posedge rst) begin
      if (rst) rd_data <= '0;
      else     rd_data <= mem[{active_bank, rd_addr}];
   end

endmodule

// File: tb/tb_pwl_table_loader.sv
// Scoreboard bench for pwl_table_loader (ADDR_BITS=4, 8+8 bit words); covers the checksum build when PWL_LOAD_CHECKSUM_EN is defined.
module tb_pwl_table_loader;

   localparam int N = 16;

   logic        clk_sys = 1'b0;
   logic        rst = 1'b1;
   logic        load_start = 1'b0;
   logic        wr_valid = 1'b0;
   logic        wr_ready;
   logic [15:0] wr_data = '0;
   logic        load_busy;
   logic        load_done;
   logic        load_err;
   logic        active_bank;
   logic [3:0]  rd_addr = '0;
   logic [15:0] rd_data;

   pwl_table_loader #(
      .ADDR_BITS(4), .OFFSET_BITS(8), .SLOPE_BITS(8)
   ) dut (
      .clk_sys(clk_sys), .rst(rst), .load_start(load_start), .wr_valid(wr_valid),
      .wr_ready(wr_ready), .wr_data(wr_data), .load_busy(load_busy), .load_done(load_done),
      .load_err(load_err), .active_bank(active_bank), .rd_addr(rd_addr), .rd_data(rd_data)
   );

   always #5 clk_sys = ~clk_sys;

   int n_pass = 0;
   int n_chk  = 0;

   // Reference table, per-entry "defined" flag, and the bank the reference expects on the read port.
   logic [15:0] mdl [2][N];
   bit          known [2][N];
   bit          bank_m = 1'b0;
   logic [15:0] sum_m = '0;
   logic [16:0] rd_q [$];

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
   endtask

   // Inputs are already set; push the expected read for the coming edge, then compare after it.
   task automatic cycle();
      logic [16:0] e;
      rd_q.push_back({known[bank_m][rd_addr], mdl[bank_m][rd_addr]});
      @(negedge clk_sys);
      e = rd_q.pop_front();
      if (e[16]) check_eq("rd_data", {16'h0, rd_data}, {16'h0, e[15:0]});
   endtask

   task automatic read_all();
      for (int a = 0; a < N; a++) begin
         rd_addr = 4'(a);
         cycle();
      end
      check_eq("bank_after_reads", active_bank, bank_m);
   endtask

   task automatic run_load(input logic [15:0] base, input bit gaps, input bit restart,
                           input logic [15:0] base2, input bit bad_trailer);
      logic [15:0] cur_base;
      logic [15:0] w;
      bit          pend;
      int          i;
      cur_base = base;
      pend     = restart;
      i        = 0;
      load_start = 1'b1;
      sum_m      = '0;
      cycle();
      load_start = 1'b0;
      check_eq("busy_in_load", load_busy, 1);
      check_eq("ready_in_load", wr_ready, 1);
`ifdef PWL_LOAD_CHECKSUM_EN
      check_eq("err_cleared", load_err, 0);
`endif
      while (i < N) begin
         w        = cur_base + 16'(i) * 16'h0101;
         wr_data  = w;
         wr_valid = gaps ? 1'($urandom_range(0, 1)) : 1'b1;
         if (pend && i == 7) begin
            wr_valid   = 1'b1;
            load_start = 1'b1;
            cycle();
            load_start = 1'b0;
            pend       = 1'b0;
            i          = 0;
            cur_base   = base2;
            sum_m      = '0;
            check_eq("restart_busy", load_busy, 1);
            check_eq("restart_bank", active_bank, bank_m);
         end else if (wr_valid) begin
            mdl[!bank_m][i]   = w;
            known[!bank_m][i] = 1'b1;
            sum_m             = sum_m + w;
`ifdef PWL_LOAD_CHECKSUM_EN
            cycle();
`else
            if (i == N - 1) begin
               cycle();
               bank_m = !bank_m;
               check_eq("swap_bank", active_bank, bank_m);
               check_eq("swap_done", load_done, 1);
               check_eq("swap_idle", load_busy, 0);
               wr_valid = 1'b0;
               cycle();
               check_eq("done_one_cycle", load_done, 0);
            end else begin
               cycle();
            end
`endif
            i++;
         end else begin
            cycle();
         end
      end
`ifdef PWL_LOAD_CHECKSUM_EN
      wr_valid = 1'b1;
      wr_data  = sum_m + (bad_trailer ? 16'd1 : 16'd0);
      cycle();
      if (!bad_trailer) begin
         bank_m = !bank_m;
         check_eq("sum_ok_bank", active_bank, bank_m);
         check_eq("sum_ok_done", load_done, 1);
         check_eq("sum_ok_err", load_err, 0);
      end else begin
         check_eq("sum_bad_bank", active_bank, bank_m);
         check_eq("sum_bad_done", load_done, 0);
         check_eq("sum_bad_err", load_err, 1);
         check_eq("sum_bad_ready", wr_ready, 0);
      end
      wr_valid = 1'b0;
      cycle();
      check_eq("done_one_cycle", load_done, 0);
      check_eq("err_sticky", load_err, bad_trailer);
`else
      if (bad_trailer) check_eq("no_trailer_err", load_err, 0);
`endif
      wr_valid = 1'b0;
   endtask

   initial begin
      for (int b = 0; b < 2; b++)
         for (int a = 0; a < N; a++) begin
            mdl[b][a]   = '0;
            known[b][a] = 1'b1;
         end

      // Reset state
      @(negedge clk_sys);
      @(negedge clk_sys);
      check_eq("rst_rd_data", {16'h0, rd_data}, 0);
      check_eq("rst_bank", active_bank, 0);
      check_eq("rst_ready", wr_ready, 0);
      check_eq("rst_busy", load_busy, 0);
      check_eq("rst_done", load_done, 0);
      check_eq("rst_err", load_err, 0);
      rst = 1'b0;
      read_all();

      // wr_valid in IDLE is ignored
      wr_valid = 1'b1;
      wr_data  = 16'hFFFF;
      cycle();
      check_eq("idle_ready", wr_ready, 0);
      check_eq("idle_busy", load_busy, 0);
      wr_valid = 1'b0;
      read_all();

      // Continuous load, rd_addr held at 3 across the swap edge
      rd_addr = 4'd3;
      run_load(16'h0000, 1'b0, 1'b0, 16'h0000, 1'b0);
      rd_addr = 4'd5;
      cycle();
      check_eq("rd5_value", {16'h0, rd_data}, 32'h0505);
      read_all();

      // Gapped load restarted at word 7; only the second stream may survive
      rd_addr = 4'd3;
      run_load(16'h5A00, 1'b1, 1'b1, 16'hC031, 1'b0);
      read_all();

`ifdef PWL_LOAD_CHECKSUM_EN
      run_load(16'h1234, 1'b1, 1'b0, 16'h0000, 1'b0);
      read_all();
      run_load(16'h7700, 1'b0, 1'b0, 16'h0000, 1'b1);
      read_all();
      check_eq("err_held", load_err, 1);
`endif

      // Reset in the middle of a load
      load_start = 1'b1;
      cycle();
      load_start = 1'b0;
      for (int i = 0; i < 9; i++) begin
         wr_valid = 1'b1;
         wr_data  = 16'hEE00 + 16'(i);
         cycle();
         known[!bank_m][i] = 1'b0;
      end
      wr_valid = 1'b0;
      @(posedge clk_sys);
      #2 rst = 1'b1;
      #1;
      check_eq("arst_rd_data", {16'h0, rd_data}, 0);
      check_eq("arst_bank", active_bank, 0);
      check_eq("arst_ready", wr_ready, 0);
      check_eq("arst_busy", load_busy, 0);
      check_eq("arst_done", load_done, 0);
      check_eq("arst_err", load_err, 0);
      bank_m = 1'b0;
      rd_q.delete();
      @(negedge clk_sys);
      rst = 1'b0;
      rd_addr = 4'd3;
      run_load(16'h4321, 1'b0, 1'b0, 16'h0000, 1'b0);
      check_eq("post_rst_bank1", active_bank, 1);
      read_all();

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
